// File: rtl/sync_fifo_wr_arb_if.sv
// Requester write channels plus the shared sync FIFO write port.
// master: requesters and FIFO; slave: the arbiter.
interface sync_fifo_wr_arb_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     fifo_wr;
    logic [WIDTH-1:0]         fifo_din;
    logic                     fifo_full;

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr, fifo_din
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr, fifo_din
    );
endinterface

// File: rtl/sync_fifo_wr_arb.sv
// Round-robin burst arbiter feeding several write requesters into one sync FIFO.
// A grant lasts until req_last, BURST_MAX beats, or the holder drops valid;
// fifo_full stalls the burst. Define FIFO_ARB_STAT_EN to build the per-requester
// accepted-word counters; otherwise stat_cnt is tied to zero.
module sync_fifo_wr_arb #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    sync_fifo_wr_arb_if.slave           bus,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic [NUM_REQ*16-1:0]       stat_cnt
);
    localparam int unsigned IdW   = $clog2(NUM_REQ);
    localparam int unsigned BeatW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e           state_q, state_d;
    logic [IdW-1:0]   grant_q, grant_d;
    logic [IdW-1:0]   rr_q, rr_d;
    logic [BeatW-1:0] beat_q, beat_d;
    logic             sel_found;
    logic [IdW-1:0]   sel_idx;
    logic             accept;

    function automatic logic [IdW-1:0] wrap_idx(input int unsigned base, input int unsigned off);
        return IdW'((base + off) % NUM_REQ);
    endfunction

    // A word moves only in GRANT, with the holder valid, FIFO not full and not in reset
    assign accept = (state_q == StGrant) && bus.req_valid[grant_q] && !bus.fifo_full && !rst;

    // Pick the first valid requester at or above rr_q, wrapping
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!sel_found && bus.req_valid[wrap_idx(32'(rr_q), k)]) begin
                sel_found = 1'b1;
                sel_idx   = wrap_idx(32'(rr_q), k);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state: arbitrate in IDLE, count beats and end bursts in GRANT
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    state_d = StGrant;
                    grant_d = sel_idx;
                    rr_d    = wrap_idx(32'(sel_idx), 1);
                    beat_d  = '0;
                end
            end
            StGrant: begin
                // Full stalls everything, including a holder that has dropped valid
                if (!bus.fifo_full) begin
                    if (!bus.req_valid[grant_q]) begin
                        state_d = StIdle;
                        grant_d = '0;
                    end else begin
                        beat_d = beat_q + BeatW'(1);
                        if (bus.req_last[grant_q] || (beat_q == BeatW'(BURST_MAX - 1))) begin
                            state_d = StIdle;
                            grant_d = '0;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: zero-latency pass-through from the grant holder; writes blocked during reset
    always_comb begin
        busy          = (state_q == StGrant);
        grant_id      = busy ? grant_q : '0;
        bus.req_ready = '0;
        bus.fifo_wr   = accept;
        bus.fifo_din  = '0;
        if (busy) begin
            bus.fifo_din = bus.req_data[32'(grant_q) * WIDTH +: WIDTH];
            if (!rst) begin
                bus.req_ready[grant_q] = !bus.fifo_full;
            end
        end
    end

`ifdef FIFO_ARB_STAT_EN
    logic [15:0] stat_q [NUM_REQ];

    // Per-requester accepted-word counters, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                stat_q[i] <= '0;
            end
        end else if (accept && (stat_q[grant_q] != 16'hFFFF)) begin
            stat_q[grant_q] <= stat_q[grant_q] + 16'd1;
        end
    end

    // Flatten counters onto the output bus
    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            stat_cnt[i*16 +: 16] = stat_q[i];
        end
    end
`else
    assign stat_cnt = '0;
`endif

endmodule
